// File: rtl/cond_logic_if.sv
// Bundle between the ALU decoder and the conditional-execution unit.
// Optional skip counter port present when CONDLOGIC_SKIPCNT_EN is defined.
interface cond_logic_if #(
    parameter int unsigned SKIPCNT_W = 16
);
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;
`ifdef CONDLOGIC_SKIPCNT_EN
    logic [SKIPCNT_W-1:0] SkipCount;
`else
    logic unused_skipcnt_w;
    assign unused_skipcnt_w = ^SKIPCNT_W;
`endif

    // Decoder side: drives instruction controls, observes gated strobes.
    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
`ifdef CONDLOGIC_SKIPCNT_EN
        , input SkipCount
`endif
    );

    // Conditional-execution unit side.
    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
`ifdef CONDLOGIC_SKIPCNT_EN
        , output SkipCount
`endif
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds NZCV, evaluates the condition field and
// gates PC/register/memory write strobes. Optional squashed-instruction
// counter enabled by CONDLOGIC_SKIPCNT_EN.
module cond_logic #(
    parameter logic [3:0]  RESET_FLAGS = 4'b0000,
    parameter int unsigned SKIPCNT_W   = 16
) (
    input logic         clk,
    input logic         reset,
    cond_logic_if.slave bus
);
    logic [1:0] nz_q, cv_q;
    logic       n, z, c, v;
    logic       cond_ex;

    assign {n, z} = nz_q;
    assign {c, v} = cv_q;

    // Condition evaluation against the flags held before this cycle's update.
    always_comb begin
        cond_ex = 1'b1;
        case (bus.Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            default: cond_ex = 1'b1;
        endcase
    end

    // NZ and CV are separately enabled so logical ops can preserve C/V.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_q <= RESET_FLAGS[3:2];
            cv_q <= RESET_FLAGS[1:0];
        end else begin
            if (bus.FlagW[1] && cond_ex) nz_q <= bus.ALUFlags[3:2];
            if (bus.FlagW[0] && cond_ex) cv_q <= bus.ALUFlags[1:0];
        end
    end

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex;
    assign bus.RegWrite = bus.RegW & cond_ex;
    assign bus.MemWrite = bus.MemW & cond_ex;
    assign bus.Flags    = {nz_q, cv_q};

`ifdef CONDLOGIC_SKIPCNT_EN
    logic [SKIPCNT_W-1:0] skip_q;

    // Count squashed instructions, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= '0;
        end else if (!cond_ex && !(&skip_q)) begin
            skip_q <= skip_q + 1'b1;
        end
    end

    assign bus.SkipCount = skip_q;
`else
    logic unused_skipcnt_w;
    assign unused_skipcnt_w = ^SKIPCNT_W;
`endif
endmodule

// File: tb/tb_cond_logic.sv
// Directed self-checking bench for cond_logic.
module tb_cond_logic;
    localparam int unsigned SW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    cond_logic_if #(.SKIPCNT_W(SW)) bus ();

    cond_logic #(
        .RESET_FLAGS(4'b0000),
        .SKIPCNT_W  (SW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cond, input logic [1:0] fw, input logic [3:0] alu);
        bus.Cond     = cond;
        bus.FlagW    = fw;
        bus.ALUFlags = alu;
        #1;
    endtask

    // Reference decode written from the condition table, grouped by pairs.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cond);
        logic nn, zz, cc, vv, base;
        {nn, zz, cc, vv} = f;
        case (cond[3:1])
            3'd0: base = zz;
            3'd1: base = cc;
            3'd2: base = nn;
            3'd3: base = vv;
            3'd4: base = cc && !zz;
            3'd5: base = (nn == vv);
            3'd6: base = !zz && (nn == vv);
            default: base = 1'b1;
        endcase
        if (cond[3:1] == 3'd7) return 1'b1;
        return cond[0] ? !base : base;
    endfunction

    initial begin
        bus.Cond = 4'b1110; bus.ALUFlags = 4'b0000; bus.FlagW = 2'b00;
        bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
        #12;
        chk("reset_flags", 16'(bus.Flags), 16'h0);
        reset = 1'b0;

        // Load 1111, then async reset mid-cycle.
        tick();
        drive(4'b1110, 2'b11, 4'b1111);
        tick();
        chk("load_1111", 16'(bus.Flags), 16'hf);
        drive(4'b1110, 2'b00, 4'b0000);
        reset = 1'b1;
        #1;
        chk("async_reset", 16'(bus.Flags), 16'h0);
        drive(4'b0000, 2'b00, 4'b0000);
        chk("rst_eq_fail", 16'(bus.CondEx), 16'h0);
        drive(4'b0001, 2'b00, 4'b0000);
        chk("rst_ne_pass", 16'(bus.CondEx), 16'h1);
        tick();
        chk("reset_hold", 16'(bus.Flags), 16'h0);
        reset = 1'b0;

        // Flag write gating, then EQ sees the new Z one cycle later.
        drive(4'b1110, 2'b11, 4'b0110);
        chk("pre_edge_flags", 16'(bus.Flags), 16'h0);
        tick();
        chk("write_0110", 16'(bus.Flags), 16'h6);
        bus.RegW = 1'b1;
        drive(4'b0000, 2'b00, 4'b0000);
        chk("eq_regwrite", 16'(bus.RegWrite), 16'h1);
        bus.RegW = 1'b0;

        // Partial NZ-only write keeps CV.
        drive(4'b1110, 2'b11, 4'b0011);
        tick();
        chk("load_0011", 16'(bus.Flags), 16'h3);
        drive(4'b1110, 2'b10, 4'b1100);
        tick();
        chk("nz_only", 16'(bus.Flags), 16'hf);
        drive(4'b1110, 2'b01, 4'b0000);
        tick();
        chk("cv_only", 16'(bus.Flags), 16'hc);

        // Squash: flags cleared, EQ fails.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        bus.PCS = 1'b1; bus.RegW = 1'b1; bus.MemW = 1'b1;
        drive(4'b0000, 2'b11, 4'b1111);
        chk("sq_pcsrc", 16'(bus.PCSrc), 16'h0);
        chk("sq_regwrite", 16'(bus.RegWrite), 16'h0);
        chk("sq_memwrite", 16'(bus.MemWrite), 16'h0);
        tick();
        chk("sq_flags", 16'(bus.Flags), 16'h0);
        drive(4'b1110, 2'b00, 4'b0000);
        chk("al_strobes", 16'({bus.PCSrc, bus.RegWrite, bus.MemWrite}), 16'h7);
        bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;

        // Full sweep of flags x condition.
        for (int f = 0; f < 16; f++) begin
            drive(4'b1110, 2'b11, 4'(f));
            tick();
            chk("sweep_load", 16'(bus.Flags), 16'(f));
            for (int c = 0; c < 16; c++) begin
                drive(4'(c), 2'b00, 4'b0000);
                chk($sformatf("cond_f%0h_c%0h", f, c), 16'(bus.CondEx),
                    16'(ref_cond(4'(f), 4'(c))));
            end
        end

`ifdef CONDLOGIC_SKIPCNT_EN
        reset = 1'b1;
        #2;
        reset = 1'b0;
        chk("skip_reset", 16'(bus.SkipCount), 16'h0);
        drive(4'b0000, 2'b00, 4'b0000);
        tick(); chk("skip_1", 16'(bus.SkipCount), 16'h1);
        tick(); chk("skip_2", 16'(bus.SkipCount), 16'h2);
        tick(); chk("skip_3", 16'(bus.SkipCount), 16'h3);
        tick(); chk("skip_sat4", 16'(bus.SkipCount), 16'h3);
        tick(); chk("skip_sat5", 16'(bus.SkipCount), 16'h3);
        drive(4'b1110, 2'b00, 4'b0000);
        tick(); chk("skip_pass", 16'(bus.SkipCount), 16'h3);
        reset = 1'b1;
        #1;
        chk("skip_clear", 16'(bus.SkipCount), 16'h0);
        reset = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
